// File: rtl/smi_rx_streamer.sv
// Drains the 0.9 GHz / 2.4 GHz RX sample FIFOs and serialises each 32-bit word
// into bytes on the SMI data bus, one byte per host read strobe, with one-word prefetch.
module smi_rx_streamer #(
    parameter bit         MSB_FIRST     = 1'b1,
    parameter logic [7:0] UNDERRUN_BYTE = 8'h00,
    parameter int         CNT_W         = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_b,
    input  logic             i_enable,
    input  logic             i_channel_sel,
    input  logic             i_smi_soe_b,
    output logic [7:0]       o_smi_data,
    output logic             o_fifo_09_pull,
    input  logic [31:0]      i_fifo_09_pulled_data,
    input  logic             i_fifo_09_empty,
    output logic             o_fifo_24_pull,
    input  logic [31:0]      i_fifo_24_pulled_data,
    input  logic             i_fifo_24_empty,
    input  logic             i_clr_status,
    output logic             o_underrun,
    output logic [CNT_W-1:0] o_underrun_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PULL    = 2'd1,
        ST_CAPTURE = 2'd2
    } fetch_state_t;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [1:0] lane;
        lane = MSB_FIRST ? (2'd3 - idx) : idx;
        case (lane)
            2'd0:    pick_byte = word[7:0];
            2'd1:    pick_byte = word[15:8];
            2'd2:    pick_byte = word[23:16];
            2'd3:    pick_byte = word[31:24];
            default: pick_byte = word[7:0];
        endcase
    endfunction

    logic             soe_meta_r, soe_sync_r, soe_prev_r;
    fetch_state_t     state_r;
    logic             chan_r;
    logic             pull_09_r, pull_24_r;
    logic [31:0]      cur_data_r, nxt_data_r;
    logic             cur_vld_r, nxt_vld_r;
    logic [1:0]       byte_idx_r;
    logic [7:0]       smi_data_r;
    logic             underrun_r;
    logic [CNT_W-1:0] underrun_cnt_r;

    logic             take_s, capture_s, sel_empty_s, underrun_take_s;
    logic [31:0]      cap_data_s, cur_data_s, nxt_data_s;
    logic             cur_vld_s, nxt_vld_s;
    logic [1:0]       byte_idx_s;

    assign take_s          = soe_prev_r & ~soe_sync_r;
    assign capture_s       = (state_r == ST_CAPTURE);
    assign cap_data_s      = chan_r ? i_fifo_24_pulled_data : i_fifo_09_pulled_data;
    assign sel_empty_s     = i_channel_sel ? i_fifo_24_empty : i_fifo_09_empty;
    assign underrun_take_s = take_s & ~cur_vld_r & i_enable;

    // Strobe synchroniser plus edge-detect stage; flush parks all flops at idle-high.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b || !i_enable) begin
            soe_meta_r <= 1'b1;
            soe_sync_r <= 1'b1;
            soe_prev_r <= 1'b1;
        end else begin
            soe_meta_r <= i_smi_soe_b;
            soe_sync_r <= soe_meta_r;
            soe_prev_r <= soe_sync_r;
        end
    end

    // Next CUR/NXT/byte_idx: a take on the last byte and a capture may coincide,
    // in which case NXT (if valid) moves up first and the captured word backfills.
    always_comb begin
        cur_data_s = cur_data_r;
        cur_vld_s  = cur_vld_r;
        nxt_data_s = nxt_data_r;
        nxt_vld_s  = nxt_vld_r;
        byte_idx_s = byte_idx_r;
        if (take_s && cur_vld_r && (byte_idx_r == 2'd3)) begin
            byte_idx_s = 2'd0;
            if (nxt_vld_r) begin
                cur_data_s = nxt_data_r;
                cur_vld_s  = 1'b1;
                nxt_data_s = capture_s ? cap_data_s : nxt_data_r;
                nxt_vld_s  = capture_s;
            end else begin
                cur_data_s = capture_s ? cap_data_s : cur_data_r;
                cur_vld_s  = capture_s;
                nxt_vld_s  = 1'b0;
            end
        end else begin
            if (take_s && cur_vld_r) begin
                byte_idx_s = byte_idx_r + 2'd1;
            end else begin
                byte_idx_s = byte_idx_r;
            end
            if (capture_s && cur_vld_r) begin
                nxt_data_s = cap_data_s;
                nxt_vld_s  = 1'b1;
            end else if (capture_s) begin
                cur_data_s = cap_data_s;
                cur_vld_s  = 1'b1;
            end else begin
                cur_vld_s  = cur_vld_r;
            end
        end
    end

    // Buffer registers and the registered byte presented to the pads.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b || !i_enable) begin
            cur_data_r <= 32'h0000_0000;
            nxt_data_r <= 32'h0000_0000;
            cur_vld_r  <= 1'b0;
            nxt_vld_r  <= 1'b0;
            byte_idx_r <= 2'd0;
            smi_data_r <= UNDERRUN_BYTE;
        end else begin
            cur_data_r <= cur_data_s;
            nxt_data_r <= nxt_data_s;
            cur_vld_r  <= cur_vld_s;
            nxt_vld_r  <= nxt_vld_s;
            byte_idx_r <= byte_idx_s;
            smi_data_r <= cur_vld_r ? pick_byte(cur_data_r, byte_idx_r) : UNDERRUN_BYTE;
        end
    end

    // Fetch FSM: one pull in flight; channel and empty flag sampled in IDLE only.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b || !i_enable) begin
            state_r   <= ST_IDLE;
            chan_r    <= 1'b0;
            pull_09_r <= 1'b0;
            pull_24_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if ((!nxt_vld_r || !cur_vld_r) && !sel_empty_s) begin
                        state_r   <= ST_PULL;
                        chan_r    <= i_channel_sel;
                        pull_09_r <= ~i_channel_sel;
                        pull_24_r <= i_channel_sel;
                    end else begin
                        state_r   <= ST_IDLE;
                        pull_09_r <= 1'b0;
                        pull_24_r <= 1'b0;
                    end
                end
                ST_PULL: begin
                    state_r   <= ST_CAPTURE;
                    pull_09_r <= 1'b0;
                    pull_24_r <= 1'b0;
                end
                ST_CAPTURE: begin
                    state_r   <= ST_IDLE;
                    pull_09_r <= 1'b0;
                    pull_24_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    pull_09_r <= 1'b0;
                    pull_24_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky underrun flag and saturating counter; a clear beats a same-edge underrun.
    always_ff @(posedge i_sys_clk) begin
        if (!i_rst_b || i_clr_status) begin
            underrun_r     <= 1'b0;
            underrun_cnt_r <= {CNT_W{1'b0}};
        end else if (underrun_take_s) begin
            underrun_r <= 1'b1;
            if (underrun_cnt_r != {CNT_W{1'b1}}) begin
                underrun_cnt_r <= underrun_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign o_smi_data     = smi_data_r;
    assign o_fifo_09_pull = pull_09_r;
    assign o_fifo_24_pull = pull_24_r;
    assign o_underrun     = underrun_r;
    assign o_underrun_cnt = underrun_cnt_r;

endmodule
